mem_stage: RTL and testbench

Memory stage of the five-stage pipeline, directly downstream of `EXStage`. It registers the EX outputs in an EX/MEM pipeline register and accesses an internal word-addressed data memory. It resolves branches from the latched zero flag. Results are registered into a MEM/WB pipeline register for the write-back stage. The block also supports stall (hold) and flush (bubble) for hazard control.

---
 rtl/mem_stage.sv | 110 +++++++++++
 tb/tb_mem_stage.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Pipeline memory stage: EX/MEM register, word-addressed data memory, branch resolution
// and MEM/WB register, with stall (hold + bubble) and flush (bubble) support.
module mem_stage #(
  parameter int unsigned word_size  = 32,
  parameter int unsigned reg_size   = 5,
  parameter int unsigned addr_width = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 flush,
  input  logic [word_size-1:0] AddResult,
  input  logic [word_size-1:0] alu_result,
  input  logic                 zero,
  input  logic [word_size-1:0] WriteData,
  input  logic [reg_size-1:0]  destination_reg,
  input  logic [2:0]           mem_control_signals,
  input  logic [1:0]           wb_control_signals,
  output logic                 pc_src,
  output logic [word_size-1:0] branch_target,
  output logic [word_size-1:0] wb_read_data,
  output logic [word_size-1:0] wb_alu_result,
  output logic [reg_size-1:0]  wb_destination_reg,
  output logic [1:0]           wb_control_signals_out
);

  localparam int unsigned depth = 1 << addr_width;

  logic [word_size-1:0] add_result_q;
  logic [word_size-1:0] alu_result_q;
  logic                 zero_q;
  logic [word_size-1:0] write_data_q;
  logic [reg_size-1:0]  destination_reg_q;
  logic                 branch_q;
  logic                 mem_read_q;
  logic                 mem_write_q;
  logic [1:0]           wb_q;

  logic [word_size-1:0]  mem [depth];
  logic [addr_width-1:0] idx;
  logic [word_size-1:0]  read_data;

  // EX/MEM register: reset > flush > stall > load.
  always_ff @(posedge clk) begin
    if (reset) begin
      add_result_q      <= '0;
      alu_result_q      <= '0;
      zero_q            <= 1'b0;
      write_data_q      <= '0;
      destination_reg_q <= '0;
      branch_q          <= 1'b0;
      mem_read_q        <= 1'b0;
      mem_write_q       <= 1'b0;
      wb_q              <= '0;
    end else if (flush) begin
      add_result_q      <= AddResult;
      alu_result_q      <= alu_result;
      zero_q            <= zero;
      write_data_q      <= WriteData;
      destination_reg_q <= destination_reg;
      branch_q          <= 1'b0;
      mem_read_q        <= 1'b0;
      mem_write_q       <= 1'b0;
      wb_q              <= '0;
    end else if (!stall) begin
      add_result_q      <= AddResult;
      alu_result_q      <= alu_result;
      zero_q            <= zero;
      write_data_q      <= WriteData;
      destination_reg_q <= destination_reg;
      branch_q          <= mem_control_signals[2];
      mem_read_q        <= mem_control_signals[1];
      mem_write_q       <= mem_control_signals[0];
      wb_q              <= wb_control_signals;
    end
  end

  // Byte address, word indexed; upper bits wrap modulo the memory depth.
  assign idx       = alu_result_q[addr_width+1:2];
  assign read_data = mem[idx];

  // A held store fires once, on the first non-stalled edge; reset discards it.
  always_ff @(posedge clk) begin
    if (!reset && mem_write_q && !stall) begin
      mem[idx] <= write_data_q;
    end
  end

  // Load data is always captured, so mem_read only qualifies the data downstream.
  logic unused_mem_read;
  assign unused_mem_read = mem_read_q;

  assign pc_src        = !reset && branch_q && zero_q;
  assign branch_target = add_result_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_read_data           <= '0;
      wb_alu_result          <= '0;
      wb_destination_reg     <= '0;
      wb_control_signals_out <= '0;
    end else begin
      wb_read_data           <= read_data;
      wb_alu_result          <= alu_result_q;
      wb_destination_reg     <= destination_reg_q;
      wb_control_signals_out <= stall ? 2'b00 : wb_q;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: reset, load/store, branch, pass-through,
// stall, flush, address wrap and mid-operation reset.
module tb_mem_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic [31:0] AddResult;
  logic [31:0] alu_result;
  logic        zero;
  logic [31:0] WriteData;
  logic [4:0]  destination_reg;
  logic [2:0]  mem_control_signals;
  logic [1:0]  wb_control_signals;
  logic        pc_src;
  logic [31:0] branch_target;
  logic [31:0] wb_read_data;
  logic [31:0] wb_alu_result;
  logic [4:0]  wb_destination_reg;
  logic [1:0]  wb_control_signals_out;

  int checks;
  int failures;

  mem_stage #(
    .word_size (32),
    .reg_size  (5),
    .addr_width(8)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .stall                 (stall),
    .flush                 (flush),
    .AddResult             (AddResult),
    .alu_result            (alu_result),
    .zero                  (zero),
    .WriteData             (WriteData),
    .destination_reg       (destination_reg),
    .mem_control_signals   (mem_control_signals),
    .wb_control_signals    (wb_control_signals),
    .pc_src                (pc_src),
    .branch_target         (branch_target),
    .wb_read_data          (wb_read_data),
    .wb_alu_result         (wb_alu_result),
    .wb_destination_reg    (wb_destination_reg),
    .wb_control_signals_out(wb_control_signals_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] add, input logic [31:0] alu, input logic z,
                       input logic [31:0] wd, input logic [4:0] d, input logic [2:0] m,
                       input logic [1:0] w);
    AddResult           = add;
    alu_result          = alu;
    zero                = z;
    WriteData           = wd;
    destination_reg     = d;
    mem_control_signals = m;
    wb_control_signals  = w;
  endtask

  task automatic nop();
    drive(32'h0, 32'h0, 1'b0, 32'h0, 5'd0, 3'b000, 2'b00);
  endtask

  // Store completes at the second edge; memory is then stable for later loads.
  task automatic store_word(input logic [31:0] addr, input logic [31:0] data);
    drive(32'h0, addr, 1'b0, data, 5'd0, 3'b001, 2'b00);
    tick();
    nop();
    tick();
  endtask

  // Leaves the loaded word on wb_read_data.
  task automatic load_word(input logic [31:0] addr, input logic [4:0] d);
    drive(32'h0, addr, 1'b0, 32'h0, d, 3'b010, 2'b11);
    tick();
    nop();
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    drive($urandom, $urandom, 1'b1, $urandom, 5'($urandom), 3'b100, 2'($urandom));
    tick();
    drive($urandom, $urandom, 1'b1, $urandom, 5'($urandom), 3'b101, 2'($urandom));
    tick();
    checks++;
    if (pc_src !== 1'b0) begin
      failures++;
      $display("FAIL reset_pc_src got=%b want=0", pc_src);
    end
    checks++;
    if (branch_target !== 32'h0) begin
      failures++;
      $display("FAIL reset_branch_target got=%h want=0", branch_target);
    end
    checks++;
    if ({wb_read_data, wb_alu_result, wb_destination_reg, wb_control_signals_out} !== 71'h0)
    begin
      failures++;
      $display("FAIL reset_wb got rd=%h alu=%h dst=%0d ctl=%b want all 0", wb_read_data,
               wb_alu_result, wb_destination_reg, wb_control_signals_out);
    end
    nop();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_store_load();
    drive(32'h0, 32'h10, 1'b0, 32'hDEADBEEF, 5'd0, 3'b001, 2'b00);
    tick();
    drive(32'h0, 32'h10, 1'b0, 32'h0, 5'd9, 3'b010, 2'b11);
    tick();
    nop();
    tick();
    checks++;
    if (wb_read_data !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL store_load_data got=%h want=deadbeef", wb_read_data);
    end
    checks++;
    if (wb_destination_reg !== 5'd9 || wb_control_signals_out !== 2'b11) begin
      failures++;
      $display("FAIL store_load_wb got dst=%0d ctl=%b want dst=9 ctl=11", wb_destination_reg,
               wb_control_signals_out);
    end
  endtask

  task automatic test_branch();
    drive(32'h40, 32'h0, 1'b1, 32'h0, 5'd0, 3'b100, 2'b00);
    tick();
    checks++;
    if (pc_src !== 1'b1 || branch_target !== 32'h40) begin
      failures++;
      $display("FAIL branch_taken got pc_src=%b tgt=%h want 1 00000040", pc_src, branch_target);
    end
    drive(32'h40, 32'h0, 1'b0, 32'h0, 5'd0, 3'b100, 2'b00);
    tick();
    checks++;
    if (pc_src !== 1'b0 || branch_target !== 32'h40) begin
      failures++;
      $display("FAIL branch_not_taken got pc_src=%b tgt=%h want 0 00000040", pc_src,
               branch_target);
    end
    // zero without branch must not redirect.
    drive(32'h44, 32'h0, 1'b1, 32'h0, 5'd0, 3'b000, 2'b00);
    tick();
    checks++;
    if (pc_src !== 1'b0) begin
      failures++;
      $display("FAIL branch_zero_only got pc_src=%b want 0", pc_src);
    end
    nop();
  endtask

  task automatic test_rtype();
    store_word(32'h0C, 32'h12345678);
    drive(32'h0, 32'h0C, 1'b0, 32'hFFFFFFFF, 5'd20, 3'b000, 2'b10);
    tick();
    nop();
    tick();
    checks++;
    if (wb_alu_result !== 32'h0C || wb_destination_reg !== 5'd20 ||
        wb_control_signals_out !== 2'b10) begin
      failures++;
      $display("FAIL rtype_wb got alu=%h dst=%0d ctl=%b want 0000000c 20 10", wb_alu_result,
               wb_destination_reg, wb_control_signals_out);
    end
    load_word(32'h0C, 5'd1);
    checks++;
    if (wb_read_data !== 32'h12345678) begin
      failures++;
      $display("FAIL rtype_mem_untouched got=%h want=12345678", wb_read_data);
    end
  endtask

  task automatic test_stall();
    store_word(32'h20, 32'h11);
    drive(32'h0, 32'h20, 1'b0, 32'h55, 5'd0, 3'b001, 2'b01);
    tick();
    nop();
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (wb_control_signals_out !== 2'b00 || wb_read_data !== 32'h11) begin
        failures++;
        $display("FAIL stall_bubble%0d got ctl=%b rd=%h want ctl=00 rd=00000011", i,
                 wb_control_signals_out, wb_read_data);
      end
    end
    stall = 1'b0;
    drive(32'h0, 32'h20, 1'b0, 32'h0, 5'd3, 3'b010, 2'b11);
    tick();
    checks++;
    if (wb_control_signals_out !== 2'b01 || wb_read_data !== 32'h11) begin
      failures++;
      $display("FAIL stall_release got ctl=%b rd=%h want ctl=01 rd=00000011",
               wb_control_signals_out, wb_read_data);
    end
    nop();
    tick();
    checks++;
    if (wb_read_data !== 32'h55 || wb_destination_reg !== 5'd3 ||
        wb_control_signals_out !== 2'b11) begin
      failures++;
      $display("FAIL stall_load got rd=%h dst=%0d ctl=%b want 00000055 3 11", wb_read_data,
               wb_destination_reg, wb_control_signals_out);
    end
  endtask

  task automatic test_flush_wrap();
    store_word(32'h30, 32'h77);
    flush = 1'b1;
    drive(32'h80, 32'h30, 1'b1, 32'h99, 5'd7, 3'b101, 2'b11);
    tick();
    flush = 1'b0;
    checks++;
    if (pc_src !== 1'b0) begin
      failures++;
      $display("FAIL flush_pc_src got=%b want 0", pc_src);
    end
    nop();
    tick();
    checks++;
    if (wb_control_signals_out !== 2'b00) begin
      failures++;
      $display("FAIL flush_bubble got ctl=%b want 00", wb_control_signals_out);
    end
    load_word(32'h30, 5'd2);
    checks++;
    if (wb_read_data !== 32'h77) begin
      failures++;
      $display("FAIL flush_mem_untouched got=%h want=00000077", wb_read_data);
    end
    store_word(32'h0, 32'h1);
    store_word(32'h400, 32'hA5);
    load_word(32'h0, 5'd4);
    checks++;
    if (wb_read_data !== 32'hA5) begin
      failures++;
      $display("FAIL wrap_load got=%h want=000000a5", wb_read_data);
    end
  endtask

  task automatic test_mid_reset();
    store_word(32'h50, 32'h1);
    drive(32'h0, 32'h50, 1'b1, 32'h2, 5'd5, 3'b101, 2'b11);
    tick();
    nop();
    reset = 1'b1;
    #1;
    checks++;
    if (pc_src !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_pc_src got=%b want 0", pc_src);
    end
    tick();
    reset = 1'b0;
    checks++;
    if (wb_control_signals_out !== 2'b00 || branch_target !== 32'h0) begin
      failures++;
      $display("FAIL mid_reset_clear got ctl=%b tgt=%h want 00 0", wb_control_signals_out,
               branch_target);
    end
    load_word(32'h50, 5'd6);
    checks++;
    if (wb_read_data !== 32'h1) begin
      failures++;
      $display("FAIL mid_reset_store_dropped got=%h want=00000001", wb_read_data);
    end
  endtask

  task automatic test_back_to_back();
    drive(32'h0, 32'h60, 1'b0, 32'hCAFE, 5'd0, 3'b001, 2'b00);
    tick();
    drive(32'h0, 32'h64, 1'b0, 32'hBEEF, 5'd0, 3'b001, 2'b00);
    tick();
    drive(32'h0, 32'h60, 1'b0, 32'h0, 5'd10, 3'b010, 2'b11);
    tick();
    drive(32'h0, 32'h64, 1'b0, 32'h0, 5'd11, 3'b010, 2'b11);
    tick();
    checks++;
    if (wb_read_data !== 32'hCAFE || wb_destination_reg !== 5'd10) begin
      failures++;
      $display("FAIL b2b_first got rd=%h dst=%0d want 0000cafe 10", wb_read_data,
               wb_destination_reg);
    end
    nop();
    tick();
    checks++;
    if (wb_read_data !== 32'hBEEF || wb_destination_reg !== 5'd11) begin
      failures++;
      $display("FAIL b2b_second got rd=%h dst=%0d want 0000beef 11", wb_read_data,
               wb_destination_reg);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_store_load();
    test_branch();
    test_rtype();
    test_stall();
    test_flush_wrap();
    test_mid_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
